// File: rtl/wb_stage_if.sv
// Bus between the MEM stage / data memory and the write-back stage,
// including the register-file write port driven back to decode.
interface wb_stage_if #(
   parameter int unsigned XLEN = 64
);
   logic            mem_valid;
   logic [6:0]      mem_opcode;
   logic [4:0]      mem_rd;
   logic [2:0]      mem_func3;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_pc_plus4;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;
   logic            wb_stall;
   logic [XLEN-1:0] wdata;
   logic [4:0]      wrd;
   logic [6:0]      wopcode;
   logic            wb_valid;
   logic [63:0]     instret;
   logic            load_timeout;

   modport master (
      output mem_valid, mem_opcode, mem_rd, mem_func3, mem_alu_result, mem_pc_plus4,
      output dmem_rvalid, dmem_rdata,
      input  wb_stall, wdata, wrd, wopcode, wb_valid, instret, load_timeout
   );

   modport slave (
      input  mem_valid, mem_opcode, mem_rd, mem_func3, mem_alu_result, mem_pc_plus4,
      input  dmem_rvalid, dmem_rdata,
      output wb_stall, wdata, wrd, wopcode, wb_valid, instret, load_timeout
   );
endinterface

// File: rtl/wb_stage.sv
// RV64 write-back stage: retires MEM instructions, waits for load data,
// aligns/extends it and drives the register-file write port.
module wb_stage #(
   parameter int unsigned XLEN       = 64,
   parameter logic [6:0]  NOP_OPCODE = 7'b0010011,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [4:0]      rd_q;
   logic [2:0]      f3_q;
   logic [2:0]      off_q;
   logic            capture;
   logic            timeout_set;
   logic [5:0]      shamt;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] wdata_d;
   logic [4:0]      wrd_d;
   logic [6:0]      wopcode_d;
   logic            valid_d;

   // Shift the target field down to bit 0, then extend by size/sign.
   always_comb begin
      unique case (f3_q)
         3'b000, 3'b100: shamt = {off_q, 3'b000};
         3'b001, 3'b101: shamt = {off_q[2:1], 4'b0000};
         3'b010, 3'b110: shamt = {off_q[2], 5'b00000};
         default:        shamt = '0;
      endcase
      shifted = bus.dmem_rdata >> shamt;
      unique case (f3_q)
         3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
         3'b010:  load_val = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         3'b110:  load_val = {{(XLEN-32){1'b0}}, shifted[31:0]};
         3'b011:  load_val = shifted;
         default: load_val = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      capture     = 1'b0;
      timeout_set = 1'b0;
      wdata_d     = '0;
      wrd_d       = '0;
      wopcode_d   = NOP_OPCODE;
      valid_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_valid) begin
               if (bus.mem_opcode == OP_LOAD) begin
                  state_d = WAIT_LOAD;
                  cnt_d   = '0;
                  capture = 1'b1;
               end else begin
                  valid_d   = 1'b1;
                  wopcode_d = bus.mem_opcode;
                  unique case (bus.mem_opcode)
                     7'b0110011, 7'b0010011, 7'b0111011,
                     7'b0011011, 7'b0110111, 7'b0010111: begin
                        wrd_d   = bus.mem_rd;
                        wdata_d = bus.mem_alu_result;
                     end
                     7'b1101111, 7'b1100111: begin
                        wrd_d   = bus.mem_rd;
                        wdata_d = bus.mem_pc_plus4;
                     end
                     default: ;
                  endcase
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.dmem_rvalid) begin
               state_d   = IDLE;
               valid_d   = 1'b1;
               wrd_d     = rd_q;
               wopcode_d = OP_LOAD;
               wdata_d   = load_val;
            end else if (cnt_q + 8'd1 == TO_LIMIT) begin
               state_d     = IDLE;
               valid_d     = 1'b1;
               wrd_d       = rd_q;
               wopcode_d   = OP_LOAD;
               timeout_set = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // x0 is hardwired to zero whatever the source
      if (wrd_d == 5'd0) wdata_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         rd_q             <= '0;
         f3_q             <= '0;
         off_q            <= '0;
         bus.wb_stall     <= 1'b0;
         bus.wdata        <= '0;
         bus.wrd          <= '0;
         bus.wopcode      <= NOP_OPCODE;
         bus.wb_valid     <= 1'b0;
         bus.instret      <= '0;
         bus.load_timeout <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bus.wb_stall <= (state_d == WAIT_LOAD);
         bus.wdata    <= wdata_d;
         bus.wrd      <= wrd_d;
         bus.wopcode  <= wopcode_d;
         bus.wb_valid <= valid_d;
         if (capture) begin
            rd_q  <= bus.mem_rd;
            f3_q  <= bus.mem_func3;
            off_q <= bus.mem_alu_result[2:0];
         end
         if (valid_d) bus.instret <= bus.instret + 64'd1;
         if (timeout_set) bus.load_timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/jump/store retirement, load alignment,
// load timeout and reset during a pending load.
module tb_wb_stage;
   localparam logic [6:0] NOP  = 7'b0010011;
   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] SW   = 7'b0100011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   wb_stage_if #(.XLEN(64)) bus ();

   wb_stage #(.XLEN(64), .NOP_OPCODE(NOP), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic v, input logic [4:0] rd,
                           input logic [6:0] op, input logic [63:0] data);
      check({tag, ".valid"},  64'(bus.wb_valid), 64'(v));
      check({tag, ".wrd"},    64'(bus.wrd),      64'(rd));
      check({tag, ".wopcode"},64'(bus.wopcode),  64'(op));
      check({tag, ".wdata"},  bus.wdata,         data);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] pc4);
      bus.mem_valid      = 1'b1;
      bus.mem_opcode     = op;
      bus.mem_rd         = rd;
      bus.mem_func3      = f3;
      bus.mem_alu_result = alu;
      bus.mem_pc_plus4   = pc4;
      @(negedge clk);
      bus.mem_valid = 1'b0;
   endtask

   // Load with rvalid delivered so that wb_stall is high for 'waits' cycles.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                          input logic [4:0] rd, input logic [63:0] rdata, input int waits,
                          input logic [63:0] exp);
      send(LOAD, rd, f3, {61'h200, off}, 64'h0);
      check({tag, ".stall0"}, 64'(bus.wb_stall), 64'd1);
      check({tag, ".nop"},    64'(bus.wb_valid), 64'd0);
      for (int i = 1; i < waits; i++) begin
         // MEM keeps offering an instruction; it must be ignored while waiting
         bus.mem_valid = 1'b1; bus.mem_opcode = ADD; bus.mem_rd = 5'd9;
         @(negedge clk);
         bus.mem_valid = 1'b0;
         check({tag, ".stall"}, 64'(bus.wb_stall), 64'd1);
         check({tag, ".hold"},  64'(bus.wb_valid), 64'd0);
      end
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rdata;
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      check_wr(tag, 1'b1, rd, LOAD, exp);
      check({tag, ".unstall"}, 64'(bus.wb_stall), 64'd0);
   endtask

   initial begin
      bus.mem_valid = 1'b0; bus.mem_opcode = '0; bus.mem_rd = '0; bus.mem_func3 = '0;
      bus.mem_alu_result = '0; bus.mem_pc_plus4 = '0;
      bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
      repeat (2) @(negedge clk);
      check_wr("reset", 1'b0, 5'd0, NOP, 64'h0);
      check("reset.stall",   64'(bus.wb_stall),     64'd0);
      check("reset.instret", bus.instret,           64'd0);
      check("reset.timeout", 64'(bus.load_timeout), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      send(ADD, 5'd5, 3'b000, 64'h1234, 64'h0);
      check_wr("add", 1'b1, 5'd5, ADD, 64'h1234);
      @(negedge clk);
      check_wr("add.after", 1'b0, 5'd0, NOP, 64'h0);
      check("add.instret", bus.instret, 64'd1);

      // byte 3 of 0x80FF0000 is 0x80
      do_load("lb",  3'b000, 3'd3, 5'd7,  64'h0000_0000_80FF_0000, 2, 64'hFFFF_FFFF_FFFF_FF80);
      do_load("lb2", 3'b000, 3'd2, 5'd7,  64'h0000_0000_80FF_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      do_load("lbu", 3'b100, 3'd3, 5'd8,  64'h0000_0000_80FF_0000, 1, 64'h0000_0000_0000_0080);
      do_load("lhu", 3'b101, 3'd6, 5'd10, 64'hBEEF_0000_0000_0000, 3, 64'h0000_0000_0000_BEEF);
      do_load("lh",  3'b001, 3'd7, 5'd11, 64'hBEEF_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_BEEF);
      do_load("lwu", 3'b110, 3'd4, 5'd12, 64'hBEEF_0000_0000_0000, 1, 64'h0000_0000_BEEF_0000);
      do_load("lw",  3'b010, 3'd5, 5'd13, 64'h8000_0001_0000_0000, 1, 64'hFFFF_FFFF_8000_0001);
      do_load("ld",  3'b011, 3'd0, 5'd14, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF);
      do_load("f7",  3'b111, 3'd0, 5'd15, 64'h0123_4567_89AB_CDEF, 1, 64'h0);
      do_load("ld0", 3'b011, 3'd0, 5'd0,  64'h0123_4567_89AB_CDEF, 1, 64'h0);

      send(JAL, 5'd1, 3'b000, 64'h999, 64'h80);
      check_wr("jal", 1'b1, 5'd1, JAL, 64'h80);
      send(JAL, 5'd0, 3'b000, 64'h999, 64'h80);
      check_wr("jal0", 1'b1, 5'd0, JAL, 64'h0);
      send(SW, 5'd9, 3'b010, 64'h55, 64'h0);
      check_wr("sw", 1'b1, 5'd0, SW, 64'h0);
      @(negedge clk);
      check("instret.mid", bus.instret, 64'd14);

      // no rvalid: four stalled cycles, then a zero write
      send(LOAD, 5'd3, 3'b011, 64'h2000, 64'h0);
      check("to.stall0", 64'(bus.wb_stall), 64'd1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("to.stall", 64'(bus.wb_stall), 64'd1);
      end
      check("to.pending", 64'(bus.load_timeout), 64'd0);
      @(negedge clk);
      check_wr("to", 1'b1, 5'd3, LOAD, 64'h0);
      check("to.flag",    64'(bus.load_timeout), 64'd1);
      check("to.unstall", 64'(bus.wb_stall),     64'd0);
      @(negedge clk);
      check("to.instret", bus.instret,           64'd15);
      check("to.sticky",  64'(bus.load_timeout), 64'd1);

      // reset while waiting, then a late rvalid must not write
      send(LOAD, 5'd4, 3'b011, 64'h3000, 64'h0);
      check("rst.stall0", 64'(bus.wb_stall), 64'd1);
      rst = 1'b1;
      #1;
      check("rst.async", 64'(bus.wb_stall), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      bus.dmem_rvalid = 1'b0;
      check_wr("rst.late", 1'b0, 5'd0, NOP, 64'h0);
      check("rst.stall",   64'(bus.wb_stall),     64'd0);
      check("rst.instret", bus.instret,           64'd0);
      check("rst.timeout", 64'(bus.load_timeout), 64'd0);

      send(ADD, 5'd2, 3'b000, 64'h7, 64'h0);
      check_wr("post", 1'b1, 5'd2, ADD, 64'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
